// File: rtl/align_ctrl_pkg.sv
// Shared types and constants for the link-alignment sequencer.
package align_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  localparam int ERR_CNT_W = 16;

  function automatic int total_align(input int width, input int dly_depth);
    return width * dly_depth;
  endfunction

endpackage

// File: rtl/align_pos_tracker.sv
// Tracks the receiver bit position, TX word-delay select and number of
// alignments tried; bitslip wraps carry into the word delay.
module align_pos_tracker
  import align_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DLY_DEPTH = 4,
  localparam int DLY_W    = $clog2(DLY_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear_tried,
  output logic [DLY_W-1:0] dly_sel,
  output logic             last_pos
);

  localparam int TOTAL = total_align(WIDTH, DLY_DEPTH);
  localparam int TRY_W = $clog2(TOTAL);
  localparam int POS_W = $clog2(WIDTH);

  logic [TRY_W-1:0] tried_q, tried_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DLY_W-1:0] dly_q, dly_d;

  // A clear and a step on the same edge (retrain from lock) leaves one try counted.
  always_comb begin
    tried_d = clear_tried ? '0 : tried_q;
    pos_d   = pos_q;
    dly_d   = dly_q;
    if (step) begin
      tried_d = tried_d + 1'b1;
      if (pos_q == POS_W'(WIDTH - 1)) begin
        pos_d = '0;
        dly_d = dly_q + 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tried_q <= '0;
      pos_q   <= '0;
      dly_q   <= '0;
    end else begin
      tried_q <= tried_d;
      pos_q   <= pos_d;
      dly_q   <= dly_d;
    end
  end

  assign dly_sel  = dly_q;
  assign last_pos = (tried_q == TRY_W'(TOTAL - 1));

endmodule

// File: rtl/align_ctrl.sv
// Link-training sequencer: steps bitslip/word-delay until the loopback compare
// locks, then watches for loss of lock. ALIGN_CTRL_ERRCNT_EN enables O_ERR_CNT.
module align_ctrl
  import align_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DLY_DEPTH    = 4,
  parameter int SETTLE_WORDS = 4,
  parameter int LOCK_WORDS   = 16,
  parameter int UNLOCK_ERRS  = 4,
  localparam int DLY_W       = $clog2(DLY_DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 I_START,
  input  logic                 I_STB,
  input  logic                 I_MATCH,
  output logic                 O_BITSLIP,
  output logic [DLY_W-1:0]     O_DLY_SEL,
  output logic                 O_LOCKED,
  output logic                 O_FAIL,
  output logic [ERR_CNT_W-1:0] O_ERR_CNT
);

  localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
  localparam int SET_W  = $clog2(SETTLE_WORDS + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              bitslip_q, bitslip_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic              clear_tried;
  logic              last_pos;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    settle_d    = settle_q;
    bad_d       = bad_q;
    clear_tried = 1'b0;
    if (I_START) begin
      state_d     = SETTLE;
      good_d      = '0;
      settle_d    = '0;
      bad_d       = '0;
      clear_tried = 1'b1;
    end else begin
      case (state_q)
        SETTLE: if (I_STB) begin
          if (settle_q == SET_W'(SETTLE_WORDS - 1)) begin
            state_d  = CHECK;
            settle_d = '0;
            good_d   = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        CHECK: if (I_STB) begin
          if (I_MATCH) begin
            good_d = good_q + 1'b1;
            if (good_q == GOOD_W'(LOCK_WORDS - 1)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else if (last_pos) begin
            state_d = FAIL;
          end else begin
            state_d = SLIP;
          end
        end
        SLIP: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        LOCKED: if (I_STB) begin
          if (I_MATCH) begin
            bad_d = '0;
          end else begin
            bad_d = bad_q + 1'b1;
            // Retrain restarts the full sweep from the current position.
            if (bad_q == BAD_W'(UNLOCK_ERRS - 1)) begin
              state_d     = SLIP;
              clear_tried = 1'b1;
            end
          end
        end
        IDLE, FAIL: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bitslip_d = (state_d == SLIP);
    locked_d  = (state_d == LOCKED);
    fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      good_q    <= '0;
      settle_q  <= '0;
      bad_q     <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      good_q    <= good_d;
      settle_q  <= settle_d;
      bad_q     <= bad_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end

  // Stepping on entry to SLIP keeps O_DLY_SEL aligned with the pulse cycle.
  align_pos_tracker #(
    .WIDTH    (WIDTH),
    .DLY_DEPTH(DLY_DEPTH)
  ) u_pos (
    .clk        (CLK),
    .rst_n      (RST),
    .step       (bitslip_d),
    .clear_tried(clear_tried),
    .dly_sel    (O_DLY_SEL),
    .last_pos   (last_pos)
  );

  assign O_BITSLIP = bitslip_q;
  assign O_LOCKED  = locked_q;
  assign O_FAIL    = fail_q;

`ifdef ALIGN_CTRL_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 err_inc;

  always_comb begin
    err_inc = (state_q == LOCKED) && I_STB && !I_MATCH;
    err_d   = err_q;
    if (I_START)                     err_d = '0;
    else if (err_inc && err_q != '1) err_d = err_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) err_q <= '0;
    else      err_q <= err_d;
  end

  assign O_ERR_CNT = err_q;
`else
  assign O_ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_align_ctrl.sv
// Scoreboard bench for align_ctrl: expected O_DLY_SEL per bitslip pulse is
// queued with the stimulus and popped when the pulse appears.
module tb_align_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_START = 1'b0;
  logic        I_STB = 1'b0;
  logic        I_MATCH = 1'b0;
  logic        O_BITSLIP;
  logic [1:0]  O_DLY_SEL;
  logic        O_LOCKED;
  logic        O_FAIL;
  logic [15:0] O_ERR_CNT;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int base = 0;
  int stb_since = 100;
  logic prev_slip = 1'b0;
  int exp_dly_q[$];

  align_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .I_START  (I_START),
    .I_STB    (I_STB),
    .I_MATCH  (I_MATCH),
    .O_BITSLIP(O_BITSLIP),
    .O_DLY_SEL(O_DLY_SEL),
    .O_LOCKED (O_LOCKED),
    .O_FAIL   (O_FAIL),
    .O_ERR_CNT(O_ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: every pulse must be expected, carry the queued delay
  // select, and respect the spacing rule.
  always @(negedge CLK) begin
    if (!RST) begin
      prev_slip <= 1'b0;
      stb_since <= 100;
    end else begin
      if (O_BITSLIP) begin
        pulses <= pulses + 1;
        chk("pulse_expected", exp_dly_q.size() > 0, 1);
        if (exp_dly_q.size() > 0) chk("pulse_dly", O_DLY_SEL, exp_dly_q.pop_front());
        chk("pulse_gap", prev_slip, 0);
        chk("pulse_spacing", stb_since >= 5, 1);
        stb_since <= 0;
      end else if (I_STB) begin
        stb_since <= stb_since + 1;
      end
      prev_slip <= O_BITSLIP;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start();
    tick();
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
  endtask

  task automatic strobe(input logic m);
    tick();
    I_STB   = 1'b1;
    I_MATCH = m;
    tick();
    I_STB   = 1'b0;
    I_MATCH = 1'b0;
  endtask

  // Channel model: the stream matches once `target` slips have been applied.
  task automatic train(input int target, input int budget);
    int n;
    n = 0;
    while (!O_LOCKED && !O_FAIL && n < budget) begin
      strobe((pulses - base) >= target);
      n++;
    end
    chk("train_done", O_LOCKED || O_FAIL, 1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    tick();
    exp_dly_q.delete();
    base = pulses;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_err;
    RST = 1'b1;
    #3 RST = 1'b0;
    #1;
    chk("rst_bitslip", O_BITSLIP, 0);
    chk("rst_dly", O_DLY_SEL, 0);
    chk("rst_locked", O_LOCKED, 0);
    chk("rst_fail", O_FAIL, 0);
    chk("rst_err", O_ERR_CNT, 0);
    repeat (2) tick();
    RST = 1'b1;
    tick();
    base = pulses;

    // 1: matching from the start, lock one cycle after the 20th strobe
    start();
    for (int i = 0; i < 19; i++) strobe(1'b1);
    chk("s1_prelock", O_LOCKED, 0);
    strobe(1'b1);
    chk("s1_lock", O_LOCKED, 1);
    chk("s1_pulses", pulses - base, 0);
    chk("s1_dly", O_DLY_SEL, 0);

    // 5: error tolerance while locked, then loss of lock
    repeat (3) strobe(1'b0);
    strobe(1'b1);
    repeat (3) strobe(1'b0);
`ifdef ALIGN_CTRL_ERRCNT_EN
    exp_err = 6;
`else
    exp_err = 0;
`endif
    chk("s5_hold", O_LOCKED, 1);
    chk("s5_err6", O_ERR_CNT, exp_err);
    strobe(1'b1);
    exp_dly_q.push_back(0);
    repeat (3) strobe(1'b0);
    chk("s5_hold2", O_LOCKED, 1);
    chk("s5_noslip", O_BITSLIP, 0);
    strobe(1'b0);
`ifdef ALIGN_CTRL_ERRCNT_EN
    exp_err = 10;
`else
    exp_err = 0;
`endif
    chk("s5_unlock", O_LOCKED, 0);
    chk("s5_slip", O_BITSLIP, 1);
    chk("s5_err10", O_ERR_CNT, exp_err);
    tick();
    chk("s5_sb", exp_dly_q.size(), 0);

    // 2: match after 3 slips
    do_reset();
    repeat (3) exp_dly_q.push_back(0);
    start();
    train(3, 400);
    chk("s2_lock", O_LOCKED, 1);
    chk("s2_pulses", pulses - base, 3);
    chk("s2_dly", O_DLY_SEL, 0);
    chk("s2_sb", exp_dly_q.size(), 0);

    // 3: match at position 10, delay select carries on the 8th pulse
    do_reset();
    for (int k = 1; k <= 10; k++) exp_dly_q.push_back(k >= 8 ? 1 : 0);
    start();
    train(10, 600);
    chk("s3_lock", O_LOCKED, 1);
    chk("s3_pulses", pulses - base, 10);
    chk("s3_dly", O_DLY_SEL, 1);
    chk("s3_sb", exp_dly_q.size(), 0);

    // 6: asynchronous reset in the middle of SETTLE
    start();
    chk("s6_start_unlock", O_LOCKED, 0);
    chk("s6_pre_dly", O_DLY_SEL, 1);
    strobe(1'b1);
    strobe(1'b1);
    @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    chk("s6_rst_dly", O_DLY_SEL, 0);
    chk("s6_rst_locked", O_LOCKED, 0);
    chk("s6_rst_fail", O_FAIL, 0);
    chk("s6_rst_bitslip", O_BITSLIP, 0);
    chk("s6_rst_err", O_ERR_CNT, 0);
    tick();
    RST = 1'b1;
    base = pulses;
    repeat (20) strobe(1'b0);
    chk("s6_idle_pulses", pulses - base, 0);
    chk("s6_idle_locked", O_LOCKED, 0);
    chk("s6_idle_fail", O_FAIL, 0);

    // 4: never matches, 31 pulses then FAIL; restart resumes from kept position
    do_reset();
    for (int k = 1; k <= 31; k++) exp_dly_q.push_back(k / 8);
    start();
    train(1000000, 400);
    chk("s4_fail", O_FAIL, 1);
    chk("s4_locked", O_LOCKED, 0);
    chk("s4_pulses", pulses - base, 31);
    chk("s4_dly", O_DLY_SEL, 3);
    repeat (10) strobe(1'b0);
    chk("s4_hold_pulses", pulses - base, 31);
    chk("s4_hold_fail", O_FAIL, 1);
    start();
    chk("s4_restart_fail", O_FAIL, 0);
    exp_dly_q.push_back(0);
    train(32, 100);
    chk("s4_relock", O_LOCKED, 1);
    chk("s4_re_pulses", pulses - base, 32);
    chk("s4_re_dly", O_DLY_SEL, 0);
    chk("s4_sb", exp_dly_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
